// File: rtl/repadd_pkg.sv
// repadd_pkg: shared types and defaults for the repeated-addition multiplier.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   REPADD_WIDTH  : default operand width in bits
package repadd_pkg;

  localparam int unsigned REPADD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/repadd_ctrl.sv
// repadd_ctrl: controller FSM for repadd_mult.
// Ports:
//   clock   in  rising-edge clock
//   reset   in  synchronous active-high reset
//   start   in  multiply request, honoured only in IDLE
//   zero_op in  operand about to be loaded is zero (skip RUN)
//   last    in  counter equals 1, the current add is the final one
//   load    out load A and C from the operands
//   clear   out clear the product register
//   add_en  out accumulate A into P this cycle
//   dec_en  out decrement C this cycle
//   ready   out high in IDLE
//   busy    out high in RUN
//   done    out one-cycle pulse in DONE
module repadd_ctrl
  import repadd_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic zero_op,
  input  logic last,
  output logic load,
  output logic clear,
  output logic add_en,
  output logic dec_en,
  output logic ready,
  output logic busy,
  output logic done
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clear      = 1'b0;
    add_en     = 1'b0;
    dec_en     = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          clear      = 1'b1;
          state_next = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        add_en = 1'b1;
        dec_en = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/repadd_mult.sv
// repadd_mult: unsigned multiplier by repeated addition with start/done handshake.
// The addend A is accumulated into P once per cycle while the counter C runs
// down to zero; P is 2*WIDTH bits so the product never overflows.
// Optional feature: define REPADD_SWAP_EN to load the smaller operand into C
// (fewer iterations); the product is identical either way.
// Ports:
//   clock   in  rising-edge clock
//   reset   in  synchronous active-high reset
//   start   in  request, accepted only while ready=1
//   a_in    in  multiplicand, sampled on accept
//   b_in    in  multiplier, sampled on accept
//   ready   out high in IDLE
//   busy    out high in RUN
//   done    out one-cycle pulse, product valid
//   product out accumulator register P (held until the next accept)
module repadd_mult
  import repadd_pkg::*;
#(
  parameter int unsigned WIDTH = REPADD_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   c_reg;
  logic [2*WIDTH-1:0] p_reg;

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] c_sel;
  logic             zero_op;
  logic             last;
  logic             load;
  logic             clear;
  logic             add_en;
  logic             dec_en;

`ifdef REPADD_SWAP_EN
  // Smaller operand drives the iteration count; on a tie a_in stays the addend.
  always_comb begin
    if (a_in >= b_in) begin
      a_sel = a_in;
      c_sel = b_in;
    end else begin
      a_sel = b_in;
      c_sel = a_in;
    end
  end
`else
  always_comb begin
    a_sel = a_in;
    c_sel = b_in;
  end
`endif

  // Evaluated on the operands being loaded so a zero operand skips RUN entirely.
  assign zero_op = (a_sel == '0) || (c_sel == '0);
  assign last    = (c_reg == ONE);

  repadd_ctrl u_ctrl (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .zero_op (zero_op),
    .last    (last),
    .load    (load),
    .clear   (clear),
    .add_en  (add_en),
    .dec_en  (dec_en),
    .ready   (ready),
    .busy    (busy),
    .done    (done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg <= '0;
      c_reg <= '0;
      p_reg <= '0;
    end else begin
      if (load) begin
        a_reg <= a_sel;
        c_reg <= c_sel;
      end else if (dec_en) begin
        c_reg <= c_reg - ONE;
      end
      if (clear) begin
        p_reg <= '0;
      end else if (add_en) begin
        p_reg <= p_reg + {{WIDTH{1'b0}}, a_reg};
      end
    end
  end

  assign product = p_reg;

endmodule
